nvme_ctrl_state: RTL and testbench
==================================

// Module: nvme_ctrl_state
// PURPOSE
// Controller enable/shutdown sequencer for the NVMe register block. Watches the host-written CC
// register level and drives the CSTS register contents (RDY, CFS, SHST). Handshakes with the
// internal queue/datapath logic for init, shutdown and controller-reset phases.
// Sits between the register file (CC out, CSTS in) and the admin-queue/datapath engines.
// PARAMETERS
// TIMEOUT_CYCLES  1000  clocks allowed for any req/ack phase before declaring fatal (>=2)
// CNT_W           16    timeout counter width; TIMEOUT_CYCLES must be < 2**CNT_W
// PORTS
// clk        in   1   single clock domain
// reset_n    in   1   asynchronous, active-low reset
// cc         in   32  current CC register; uses EN=cc[0], SHN=cc[15:14]; other bits ignored
// csts       out  32  CSTS value: [0]RDY [1]CFS [3:2]SHST, [31:4]=0
// init_req   out  1   request datapath/queue init; held high until init_ack
// init_ack   in   1   init complete (single-cycle or level, sampled only while init_req=1)
// shdn_req   out  1   request orderly shutdown; held high until shdn_ack
// shdn_ack   in   1   shutdown complete (sampled only while shdn_req=1)
// rst_req    out  1   request internal controller reset; held high until rst_ack
// rst_ack    in   1   internal reset complete (sampled only while rst_req=1)
// state_o    out  3   current FSM state encoding (debug)
// BEHAVIOUR
// - Reset: state=DISABLED(0), csts=0, init_req=shdn_req=rst_req=0, counter=0.
// - All outputs registered; updated in the same clock edge as the state transition (1-cycle latency
//   from sampled input to output change). Acks not sampled outside their req phase.
// - States: DISABLED=0 ENABLING=1 READY=2 SHUTDOWN=3 SHDN_DONE=4 DISABLING=5 FATAL=6.
// - DISABLED: RDY=0. EN=1 -> ENABLING, init_req=1, counter=0.
// - ENABLING: counter++ each cycle. init_ack -> READY, init_req=0, RDY=1. EN=0 -> DISABLING
//   (init_req=0, rst_req=1). counter==TIMEOUT_CYCLES-1 without ack -> FATAL, CFS=1, init_req=0.
// - READY: RDY=1. EN=0 -> DISABLING. Else SHN!=00 -> SHUTDOWN, SHST=01, shdn_req=1, counter=0.
// - SHUTDOWN: counter++. shdn_ack -> SHDN_DONE, SHST=10, shdn_req=0. EN=0 -> DISABLING
//   (shdn_req=0). Timeout -> FATAL, CFS=1, shdn_req=0.
// - SHDN_DONE: SHST=10, RDY=1 held. SHN changes ignored. EN=0 -> DISABLING.
// - FATAL: CFS=1, all reqs 0, RDY keeps prior value. Only exit: EN=0 -> DISABLING.
// - DISABLING: rst_req=1, counter restarts at 0. RDY and CFS hold. rst_ack -> DISABLED with
//   RDY=0, CFS=0, SHST=00, rst_req=0. Timeout -> DISABLED, RDY=0, SHST=00, CFS=1 (sticky until next
//   successful DISABLING). EN re-asserted during DISABLING is ignored until DISABLED is reached.
// - Priority when events coincide: EN=0 > ack > timeout > SHN. Ack on the timeout cycle counts as
//   success.
// - Exactly one of init_req/shdn_req/rst_req may be high at any time.
// - Mid-operation async reset: immediate return to reset values regardless of state.
// TESTING
// 1 EN 0->1, init_ack 5 cycles after init_req -> RDY=1 one cycle after ack; csts=32'h1.
// 2 READY, SHN=01 -> csts=32'h5 (SHST=01), shdn_req=1; shdn_ack -> csts=32'h9, shdn_req=0.
// 3 EN=1, TIMEOUT_CYCLES=8, no init_ack -> CFS=1 after 8 cycles; then EN=0 and rst_ack -> csts=0.
// 4 ENABLING, EN=0 and init_ack on the same cycle -> DISABLING, rst_req=1, RDY stays 0.
// 5 READY, EN=0 -> rst_req=1, RDY=1 held; rst_ack -> csts=0 next cycle, state_o=0.
// 6 reset_n pulled low in SHUTDOWN -> all reqs 0, csts=0 asynchronously; re-enable works.

Source files
------------

// File: rtl/nvme_ctrl_state.sv
// nvme_ctrl_state: controller enable/shutdown sequencer for the NVMe register block.
// Follows the host-written CC register and produces the CSTS status bits (RDY, CFS, SHST).
// It also handshakes with the queue/datapath engines for the init, shutdown and reset phases.
// Ports:
//   clk, reset_n        clock, asynchronous active-low reset
//   cc[31:0]            CC register level (EN=cc[0], SHN=cc[15:14])
//   csts[31:0]          CSTS value: [0]RDY [1]CFS [3:2]SHST, rest zero
//   init_req/init_ack   datapath init handshake
//   shdn_req/shdn_ack   orderly shutdown handshake
//   rst_req/rst_ack     internal controller reset handshake
//   state_o[2:0]        current sequencer state (debug)
module nvme_ctrl_state #(
  parameter int unsigned TIMEOUT_CYCLES = 1000,
  parameter int unsigned CNT_W          = 16
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] cc,
  output logic [31:0] csts,
  output logic        init_req,
  input  logic        init_ack,
  output logic        shdn_req,
  input  logic        shdn_ack,
  output logic        rst_req,
  input  logic        rst_ack,
  output logic [2:0]  state_o
);

  localparam int unsigned CSTS_PAD_W = 28;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    DISABLED  = 3'd0,
    ENABLING  = 3'd1,
    READY     = 3'd2,
    SHUTDOWN  = 3'd3,
    SHDN_DONE = 3'd4,
    DISABLING = 3'd5,
    FATAL     = 3'd6
  } state_e;

  state_e           state_q, state_d;
  logic             rdy_q, rdy_d;
  logic             cfs_q, cfs_d;
  logic [1:0]       shst_q, shst_d;
  logic             init_req_q, init_req_d;
  logic             shdn_req_q, shdn_req_d;
  logic             rst_req_q, rst_req_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic       en_c;
  logic [1:0] shn_c;
  logic       timeout_c;
  logic       unused_cc;

  assign en_c      = cc[0];
  assign shn_c     = cc[15:14];
  assign unused_cc = ^{cc[31:16], cc[13:1]};
  // The phase counter is only meaningful while a req is outstanding.
  assign timeout_c = (cnt_q == CNT_LAST);

  // State and status registers
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= DISABLED;
      rdy_q      <= 1'b0;
      cfs_q      <= 1'b0;
      shst_q     <= 2'b00;
      init_req_q <= 1'b0;
      shdn_req_q <= 1'b0;
      rst_req_q  <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      rdy_q      <= rdy_d;
      cfs_q      <= cfs_d;
      shst_q     <= shst_d;
      init_req_q <= init_req_d;
      shdn_req_q <= shdn_req_d;
      rst_req_q  <= rst_req_d;
      cnt_q      <= cnt_d;
    end
  end

  // Next state and next register values; EN=0 beats ack, ack beats timeout, timeout beats SHN
  always_comb begin
    state_d    = state_q;
    rdy_d      = rdy_q;
    cfs_d      = cfs_q;
    shst_d     = shst_q;
    init_req_d = init_req_q;
    shdn_req_d = shdn_req_q;
    rst_req_d  = rst_req_q;
    cnt_d      = cnt_q;

    case (state_q)
      DISABLED: begin
        if (en_c) begin
          state_d    = ENABLING;
          init_req_d = 1'b1;
          cnt_d      = '0;
        end
      end

      ENABLING: begin
        if (!en_c) begin
          state_d    = DISABLING;
          init_req_d = 1'b0;
          rst_req_d  = 1'b1;
          cnt_d      = '0;
        end else if (init_ack) begin
          state_d    = READY;
          init_req_d = 1'b0;
          rdy_d      = 1'b1;
        end else if (timeout_c) begin
          state_d    = FATAL;
          init_req_d = 1'b0;
          cfs_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      READY: begin
        if (!en_c) begin
          state_d   = DISABLING;
          rst_req_d = 1'b1;
          cnt_d     = '0;
        end else if (shn_c != 2'b00) begin
          state_d    = SHUTDOWN;
          shst_d     = 2'b01;
          shdn_req_d = 1'b1;
          cnt_d      = '0;
        end
      end

      SHUTDOWN: begin
        if (!en_c) begin
          state_d    = DISABLING;
          shdn_req_d = 1'b0;
          rst_req_d  = 1'b1;
          cnt_d      = '0;
        end else if (shdn_ack) begin
          state_d    = SHDN_DONE;
          shst_d     = 2'b10;
          shdn_req_d = 1'b0;
        end else if (timeout_c) begin
          state_d    = FATAL;
          shdn_req_d = 1'b0;
          cfs_d      = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      SHDN_DONE, FATAL: begin
        if (!en_c) begin
          state_d   = DISABLING;
          rst_req_d = 1'b1;
          cnt_d     = '0;
        end
      end

      DISABLING: begin
        // EN is deliberately ignored until DISABLED is reached.
        if (rst_ack) begin
          state_d   = DISABLED;
          rst_req_d = 1'b0;
          rdy_d     = 1'b0;
          cfs_d     = 1'b0;
          shst_d    = 2'b00;
        end else if (timeout_c) begin
          state_d   = DISABLED;
          rst_req_d = 1'b0;
          rdy_d     = 1'b0;
          cfs_d     = 1'b1;
          shst_d    = 2'b00;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      default: begin
        state_d    = DISABLED;
        init_req_d = 1'b0;
        shdn_req_d = 1'b0;
        rst_req_d  = 1'b0;
        rdy_d      = 1'b0;
        shst_d     = 2'b00;
      end
    endcase
  end

  assign csts     = {CSTS_PAD_W'(0), shst_q, cfs_q, rdy_q};
  assign init_req = init_req_q;
  assign shdn_req = shdn_req_q;
  assign rst_req  = rst_req_q;
  assign state_o  = state_q;

endmodule

// File: tb/tb_nvme_ctrl_state.sv
// tb_nvme_ctrl_state: directed spec scenarios plus randomized CC/ack traffic for nvme_ctrl_state.
// Expected CSTS/req/state values come from a phase-level model and flow through a queue.
// A monitor drains that queue one entry per clock.
module tb_nvme_ctrl_state;

  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] cc;
  logic [31:0] csts;
  logic        init_req, init_ack;
  logic        shdn_req, shdn_ack;
  logic        rst_req, rst_ack;
  logic [2:0]  state_o;

  nvme_ctrl_state #(.TIMEOUT_CYCLES(TO), .CNT_W(16)) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .cc       (cc),
    .csts     (csts),
    .init_req (init_req),
    .init_ack (init_ack),
    .shdn_req (shdn_req),
    .shdn_ack (shdn_ack),
    .rst_req  (rst_req),
    .rst_ack  (rst_ack),
    .state_o  (state_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] csts;
    logic [2:0]  reqs;   // {rst, shdn, init}
    logic [2:0]  st;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Phase-level model: which phase the controller is in, status bits, cycles spent in the phase.
  int       m_st;
  bit       m_rdy;
  bit       m_cfs;
  bit [1:0] m_shst;
  int       m_elapsed;

  task automatic model_reset();
    m_st = 0; m_rdy = 0; m_cfs = 0; m_shst = 0; m_elapsed = 0;
  endtask

  function automatic exp_t model_out();
    exp_t e;
    e.csts = {28'd0, m_shst, m_cfs, m_rdy};
    e.reqs = {m_st == 5, m_st == 3, m_st == 1};
    e.st   = 3'(m_st);
    return e;
  endfunction

  task automatic model_step(input bit en, input bit [1:0] shn, input bit ia, input bit sa, input bit ra);
    bit ack, expired;
    ack     = (m_st == 1 && ia) || (m_st == 3 && sa) || (m_st == 5 && ra);
    expired = (m_elapsed >= int'(TO) - 1);
    if (m_st == 5) begin
      if (ack || expired) begin
        m_st = 0; m_rdy = 0; m_shst = 0; m_cfs = !ack;
      end else m_elapsed++;
    end else if (m_st != 0 && !en) begin
      m_st = 5; m_elapsed = 0;
    end else begin
      case (m_st)
        0: if (en) begin m_st = 1; m_elapsed = 0; end
        1: if (ack) begin m_st = 2; m_rdy = 1; end
           else if (expired) begin m_st = 6; m_cfs = 1; end
           else m_elapsed++;
        2: if (shn != 0) begin m_st = 3; m_shst = 1; m_elapsed = 0; end
        3: if (ack) begin m_st = 4; m_shst = 2; end
           else if (expired) begin m_st = 6; m_cfs = 1; end
           else m_elapsed++;
        default: ;
      endcase
    end
  endtask

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_tests++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, got, want, $time);
    end
  endtask

  // Drive one cycle of inputs at the falling edge; expected result of the next rising edge is queued.
  task automatic step(input bit en, input bit [1:0] shn, input bit ia, input bit sa, input bit ra);
    @(negedge clk);
    cc       = $urandom;
    cc[0]    = en;
    cc[15:14] = shn;
    init_ack = ia;
    shdn_ack = sa;
    rst_ack  = ra;
    model_step(en, shn, ia, sa, ra);
    exp_q.push_back(model_out());
  endtask

  task automatic after_edge();
    @(posedge clk);
    #2;
  endtask

  // Monitor: every registered update is compared against the head of the queue.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("mon_csts",  csts, e.csts);
        chk("mon_reqs",  32'({rst_req, shdn_req, init_req}), 32'(e.reqs));
        chk("mon_state", 32'(state_o), 32'(e.st));
        chk("mon_onehot", 32'($onehot0({rst_req, shdn_req, init_req})), 32'd1);
      end
    end
  end

  initial begin
    reset_n = 1'b0; cc = '0; init_ack = 0; shdn_ack = 0; rst_ack = 0;
    model_reset();
    #3;
    chk("reset_csts",  csts, 32'h0);
    chk("reset_reqs",  32'({rst_req, shdn_req, init_req}), 32'h0);
    chk("reset_state", 32'(state_o), 32'h0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;

    // Enable with init_ack several cycles after init_req
    step(1, 0, 0, 0, 0);
    after_edge(); chk("s1_init_req", 32'(init_req), 32'h1);
    repeat (4) step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    after_edge(); chk("s1_csts_ready", csts, 32'h1);

    // Shutdown request and completion
    step(1, 2'b01, 0, 0, 0);
    after_edge(); chk("s2_csts_shst01", csts, 32'h5);
    chk("s2_shdn_req", 32'(shdn_req), 32'h1);
    step(1, 2'b01, 0, 0, 0);
    step(1, 2'b01, 0, 1, 0);
    after_edge(); chk("s2_csts_shst10", csts, 32'h9);
    chk("s2_shdn_req_low", 32'(shdn_req), 32'h0);

    // Disable from SHDN_DONE, rst_ack returns to DISABLED
    step(0, 0, 0, 0, 0);
    after_edge(); chk("s5_rst_req", 32'(rst_req), 32'h1);
    chk("s5_csts_held", csts, 32'h9);
    step(1, 0, 0, 0, 1);
    after_edge(); chk("s5_csts_clear", csts, 32'h0);
    chk("s5_state", 32'(state_o), 32'h0);

    // Init timeout -> FATAL, then disable clears CFS
    step(1, 0, 0, 0, 0);
    repeat (TO) step(1, 0, 0, 0, 0);
    after_edge(); chk("s3_cfs", csts, 32'h2);
    chk("s3_state_fatal", 32'(state_o), 32'h6);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);
    after_edge(); chk("s3_csts_clear", csts, 32'h0);

    // EN=0 and init_ack together: disable wins
    step(1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0);
    after_edge(); chk("s4_state", 32'(state_o), 32'h5);
    chk("s4_rst_req", 32'(rst_req), 32'h1);
    chk("s4_rdy_low", csts, 32'h0);
    step(0, 0, 0, 0, 1);

    // Ready then disable with reset timeout: CFS sticky into next enable
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    after_edge(); chk("s7_rdy_held", csts, 32'h1);
    repeat (TO) step(1, 0, 0, 0, 0);
    after_edge(); chk("s7_timeout_cfs", csts, 32'h2);
    chk("s7_state", 32'(state_o), 32'h0);
    step(1, 0, 0, 0, 0);
    after_edge(); chk("s7_cfs_sticky", csts, 32'h2);
    step(1, 0, 1, 0, 0);
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1);

    // Async reset in SHUTDOWN, then re-enable
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    step(1, 2'b10, 0, 0, 0);
    after_edge(); chk("s6_in_shutdown", 32'(state_o), 32'h3);
    @(negedge clk);
    #1;
    cc = '0; init_ack = 0; shdn_ack = 0; rst_ack = 0;
    reset_n = 1'b0;
    #1;
    model_reset();
    chk("s6_async_csts", csts, 32'h0);
    chk("s6_async_reqs", 32'({rst_req, shdn_req, init_req}), 32'h0);
    chk("s6_async_state", 32'(state_o), 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1, 0, 0, 0, 0);
    step(1, 0, 1, 0, 0);
    after_edge(); chk("s6_reenable", csts, 32'h1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      bit       en;
      bit [1:0] shn;
      en  = ($urandom_range(0, 19) != 0);
      shn = ($urandom_range(0, 4) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      step(en, shn, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
    end

    after_edge();
    @(negedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
